// File: rtl/lottery_pkg.sv
// Constants and state encoding shared by the lottery entry issuer and the draw.
package lottery_pkg;

    localparam int unsigned MAX_ENTRIES = 32;
    localparam int unsigned MIN_ENTRIES = 5;
    localparam int unsigned CNT_W       = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        CLOSED
    } issuer_state_t;

endpackage

// File: rtl/lottery_entry_issuer.sv
// Accepts participant entries and turns each into a setup/strobe/hold write
// sequence for the draw queue; closes the entry window on request or when full.
module lottery_entry_issuer #(
    parameter int unsigned MAX_ENTRIES = lottery_pkg::MAX_ENTRIES,
    parameter int unsigned MIN_ENTRIES = lottery_pkg::MIN_ENTRIES,
    parameter int unsigned CNT_W       = lottery_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_bit,
    output logic             req_ready,
    input  logic             close,
    output logic             write,
    output logic             luckybit,
    output logic             stop,
    output logic             full,
    output logic             close_rej,
    output logic [CNT_W-1:0] count
);
    import lottery_pkg::*;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ENTRIES);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ENTRIES);

    issuer_state_t    state, state_d;
    logic [CNT_W-1:0] count_d;
    logic             luckybit_d, write_d, stop_d, full_d, close_rej_d;
    logic             pending_close, pending_close_d;
    logic             rst_meta, rst_sync;
    logic             close_eff, close_ok;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign close_eff = close | pending_close;
    assign close_ok  = (count >= MIN_C);

    // An accepted close in IDLE takes priority over a simultaneous entry.
    assign req_ready = rst_sync && (state == IDLE) && !stop && (count < MAX_C)
                       && !(close_eff && close_ok);

    always_comb begin
        state_d         = state;
        count_d         = count;
        luckybit_d      = luckybit;
        write_d         = 1'b0;
        stop_d          = stop;
        full_d          = full;
        close_rej_d     = 1'b0;
        pending_close_d = pending_close;
        case (state)
            IDLE: begin
                if (close_eff) begin
                    pending_close_d = 1'b0;
                    if (close_ok) begin
                        stop_d  = 1'b1;
                        state_d = CLOSED;
                    end else begin
                        close_rej_d = 1'b1;
                    end
                end
                if (req_valid && req_ready) begin
                    luckybit_d = req_bit;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                write_d         = 1'b1;
                state_d         = STROBE;
                pending_close_d = pending_close | close;
            end
            STROBE: begin
                state_d         = HOLD;
                pending_close_d = pending_close | close;
            end
            HOLD: begin
                count_d = (count < MAX_C) ? count + CNT_W'(1) : count;
                if (count_d == MAX_C) begin
                    full_d          = 1'b1;
                    stop_d          = 1'b1;
                    pending_close_d = 1'b0;
                    state_d         = CLOSED;
                end else begin
                    pending_close_d = pending_close | close;
                    state_d         = IDLE;
                end
            end
            CLOSED: begin
                stop_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // write is registered so the strobe coincides with the STROBE state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            luckybit      <= 1'b0;
            write         <= 1'b0;
            stop          <= 1'b0;
            full          <= 1'b0;
            close_rej     <= 1'b0;
            pending_close <= 1'b0;
        end else if (rst_sync) begin
            state         <= state_d;
            count         <= count_d;
            luckybit      <= luckybit_d;
            write         <= write_d;
            stop          <= stop_d;
            full          <= full_d;
            close_rej     <= close_rej_d;
            pending_close <= pending_close_d;
        end
    end

endmodule

// File: tb/tb_lottery_entry_issuer.sv
// Directed bench for lottery_entry_issuer: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_lottery_entry_issuer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_bit;
    logic       req_ready;
    logic       close;
    logic       write;
    logic       luckybit;
    logic       stop;
    logic       full;
    logic       close_rej;
    logic [5:0] count;

    int unsigned checks;
    int unsigned errors;

    lottery_entry_issuer #(
        .MAX_ENTRIES(32),
        .MIN_ENTRIES(5),
        .CNT_W      (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_bit  (req_bit),
        .req_ready(req_ready),
        .close    (close),
        .write    (write),
        .luckybit (luckybit),
        .stop     (stop),
        .full     (full),
        .close_rej(close_rej),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_bit   = 1'b0;
        close     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Starts and ends on a falling edge with the issuer in IDLE; close_at selects
    // the phase (1 SETUP, 2 STROBE, 3 HOLD) during which close is held high.
    task automatic send_entry(input logic b, input int close_at);
        int n;
        req_valid = 1'b1;
        req_bit   = b;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("entry_ready_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        close     = (close_at == 1);
        @(negedge clk);
        close = (close_at == 2);
        @(negedge clk);
        close = (close_at == 3);
        @(negedge clk);
        close = 1'b0;
    endtask

    initial begin
        int hs;
        int pulses;
        int b2b;
        logic prev_write;

        checks = 0;
        errors = 0;

        // 1) reset values and a single entry
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_luckybit", 32'(luckybit), 32'd0);
        check("rst_close_rej", 32'(close_rej), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_bit   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_setup_write", 32'(write), 32'd0);
        check("t1_setup_bit", 32'(luckybit), 32'd1);
        check("t1_setup_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t1_strobe_write", 32'(write), 32'd1);
        check("t1_strobe_bit", 32'(luckybit), 32'd1);
        @(negedge clk);
        check("t1_hold_write", 32'(write), 32'd0);
        check("t1_hold_bit", 32'(luckybit), 32'd1);
        check("t1_hold_count", 32'(count), 32'd0);
        @(negedge clk);
        check("t1_count", 32'(count), 32'd1);
        check("t1_ready", 32'(req_ready), 32'd1);

        // 2) held req_valid fills the queue
        do_reset();
        hs = 0; pulses = 0; b2b = 0; prev_write = 1'b0;
        req_valid = 1'b1;
        req_bit   = 1'b1;
        for (int i = 0; i < 150; i++) begin
            #1;
            if (req_ready) hs++;
            @(negedge clk);
            if (write && !prev_write) pulses++;
            if (write && prev_write) b2b++;
            prev_write = write;
        end
        req_valid = 1'b0;
        check("t2_handshakes", 32'(hs), 32'd32);
        check("t2_pulses", 32'(pulses), 32'd32);
        check("t2_back_to_back", 32'(b2b), 32'd0);
        check("t2_count", 32'(count), 32'd32);
        check("t2_full", 32'(full), 32'd1);
        check("t2_stop", 32'(stop), 32'd1);

        // 3) early close rejected, later close accepted
        do_reset();
        for (int i = 0; i < 3; i++) send_entry(1'(i), 0);
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
        check("t3_rej_pulse", 32'(close_rej), 32'd1);
        check("t3_rej_stop", 32'(stop), 32'd0);
        @(negedge clk);
        check("t3_rej_end", 32'(close_rej), 32'd0);
        send_entry(1'b1, 0);
        send_entry(1'b0, 0);
        check("t3_count5", 32'(count), 32'd5);
        close     = 1'b1;
        req_valid = 1'b1;
        #1;
        check("t3_ready_on_close", 32'(req_ready), 32'd0);
        @(negedge clk);
        close = 1'b0;
        check("t3_stop", 32'(stop), 32'd1);
        check("t3_no_rej", 32'(close_rej), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_closed_ready", 32'(req_ready), 32'd0);
        check("t3_closed_write", 32'(write), 32'd0);
        check("t3_closed_count", 32'(count), 32'd5);
        close = 1'b1;
        @(negedge clk);
        close     = 1'b0;
        req_valid = 1'b0;
        check("t3_closed_ignore", 32'(close_rej), 32'd0);

        // 4) close requests raised while an entry is in flight
        do_reset();
        for (int i = 0; i < 3; i++) send_entry(1'b1, 0);
        send_entry(1'b0, 2);
        #1;
        check("t4_count4", 32'(count), 32'd4);
        check("t4_ready4", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("t4_late_rej", 32'(close_rej), 32'd1);
        check("t4_stop4", 32'(stop), 32'd0);
        @(negedge clk);
        check("t4_rej_end", 32'(close_rej), 32'd0);
        send_entry(1'b1, 2);
        #1;
        check("t4_count5", 32'(count), 32'd5);
        check("t4_ready5", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t4_stop5", 32'(stop), 32'd1);
        check("t4_no_rej5", 32'(close_rej), 32'd0);

        // 5) close and req_valid together in IDLE
        do_reset();
        for (int i = 0; i < 7; i++) send_entry(1'b0, 0);
        close     = 1'b1;
        req_valid = 1'b1;
        req_bit   = 1'b1;
        #1;
        check("t5a_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        close     = 1'b0;
        req_valid = 1'b0;
        check("t5a_stop", 32'(stop), 32'd1);
        @(negedge clk);
        check("t5a_write", 32'(write), 32'd0);
        check("t5a_count", 32'(count), 32'd7);
        do_reset();
        send_entry(1'b0, 0);
        send_entry(1'b0, 0);
        close     = 1'b1;
        req_valid = 1'b1;
        req_bit   = 1'b1;
        #1;
        check("t5b_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        close     = 1'b0;
        req_valid = 1'b0;
        check("t5b_rej", 32'(close_rej), 32'd1);
        check("t5b_bit", 32'(luckybit), 32'd1);
        @(negedge clk);
        check("t5b_write", 32'(write), 32'd1);
        repeat (2) @(negedge clk);
        check("t5b_count", 32'(count), 32'd3);
        check("t5b_stop", 32'(stop), 32'd0);

        // 6) reset during the write strobe
        do_reset();
        send_entry(1'b1, 0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_write_high", 32'(write), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_write_async", 32'(write), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_count", 32'(count), 32'd0);
        check("t6_stop", 32'(stop), 32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
